fwrisc_lsu: RTL and testbench
=============================

# fwrisc_lsu

Parametrised load/store unit that sits between the fwrisc execute stage and the data bus, replacing the fixed full-word, always-`4'hf` data path. It accepts one byte, halfword or word request at a time and places store data on the correct byte lanes with the correct strobes. It extracts and sign- or zero-extends load data, and bounds every bus access with a timeout counter. Misaligned accesses are either split into two aligned bus beats or rejected with an error, depending on build configuration.

## Interface
- `ADDR_WIDTH`, default 32: width of request and bus addresses.
- `TIMEOUT`, default 0: number of cycles `dvalid` may wait for `dready` before the access is abandonned; 0 disables the timeout.
- `clock` in 1: clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `req_unsigned` in 1: zero-extend load data (LBU/LHU).
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: completion with error.
- `rsp_err_code` out 2: 00 none, 01 misaligned, 10 bus timeout.
- `daddr` out ADDR_WIDTH: word-aligned bus address, low 2 bits always 0.
- `dwdata` out 32: lane-shifted store data.
- `drdata` in 32: bus read data.
- `dstrb` out 4: byte strobes.
- `dwrite` out 1: write beat.
- `dvalid` out 1: bus beat valid.
- `dready` in 1: bus beat accepted or complete.

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE -> BEAT0 when `req_valid`. All request fields are registered at this point.
- `off = req_addr[1:0]`. The 8-bit mask is `{0001|0011|1111} << off`. Beat 0 uses `mask[3:0]`; beat 1 uses `mask[7:4]`. A split is needed when `mask[7:4] != 0`.
- Beat 0 drives `daddr = addr & ~3`, `dwdata = wdata << 8*off`, and `dstrb = mask[3:0]`.
- Beat 1 drives `daddr = (addr & ~3) + 4`, modulo 2^ADDR_WIDTH so it wraps to 0. It also drives `dwdata = wdata >> 8*(4-off)` and `dstrb = mask[7:4]`.
- Loads assemble a 64-bit value `{beat1_data, beat0_data}`, shift it right by `8*off`, then extend from bit 7, 15 or 31. Extension is zero-extension if `req_unsigned`, otherwise sign-extension.
- BEAT0 on `dready`: go to BEAT1 if a split is needed, otherwise go to RESP. BEAT1 on `dready`: go to RESP.
- RESP: `rsp_valid = 1` for exactly one cycle, then the unit returns to IDLE.
- Timeout: a counter clears on entry to each beat and increments every cycle `dvalid && !dready`. When it reaches TIMEOUT (with TIMEOUT > 0), the unit goes to RESP with `rsp_err = 1` and code 10. Beat-1 is abandoned and load data is 0. Writes already completed in beat 0 are not undone.
- Reset in any state: at the next edge, the state is IDLE and all outputs are 0. Any outstanding bus beat is abandoned without a response.

## Timing
- Reset values: `req_ready` = 1 once out of reset (0 while `reset` is high). All other outputs are 0.
- `dvalid`, `dwrite`, `daddr`, `dwdata` and `dstrb` are registered. They are stable and held while `dvalid && !dready`.
- Aligned access with `dready` tied high: request accepted in cycle N, `dvalid` in N+1, `rsp_valid` in N+2, `req_ready` in N+3.
- Split access adds 1 cycle. Each cycle of `dready` low adds 1 cycle.
- A beat completes in the cycle `dvalid && dready`. `drdata` is sampled in that cycle.
- `rsp_*` outputs are valid only while `rsp_valid` is high.
- A request presented while `req_ready` is low is ignored.

## Configuration
- `FWRISC_LSU_MISALIGN_EN` defined: misaligned accesses are split into two beats as described in Operation.
- `FWRISC_LSU_MISALIGN_EN` undefined:
  - A request needing a split goes IDLE -> RESP directly, with no bus activity.
  - The response carries `rsp_err = 1` and code 01.
  - Misaligned means half at `off = 3`, or word at `off != 0`. This is the same condition as `mask[7:4] != 0`.
  - BEAT1 logic is removed.

## Test plan
- **Aligned word load:** load word at 0x100, `drdata = 0xDEADBEEF`. Required: one beat, `daddr = 0x100`, `dstrb = 4'hf`, `rsp_rdata = 0xDEADBEEF`, `rsp_valid` 2 cycles after accept.
- **Byte loads at offset 2:** load byte at 0x102 with `drdata = 0x0080_0000`. Signed gives `0xFFFFFF80`; unsigned gives `0x00000080`.
- **Store half at offset 2:** `req_wdata = 0x1234` at 0x202. Required: `dstrb = 4'b1100`, `dwdata = 0x12340000`, one beat.
- **Misaligned word store at 0x301:**
  - With the macro: beat 0 has `daddr = 0x300`, `dstrb = 1110`; beat 1 has `daddr = 0x304`, `dstrb = 0001`.
  - With the macro, a word load at `0xFFFFFFFE` wraps beat 1 to `daddr = 0`.
  - Without the macro: no `dvalid`, and `rsp_err_code = 01`.
- **Timeout:** TIMEOUT = 4, `dready` held low. Required: `dvalid` high for 4 cycles, then `rsp_valid` with code 10, then `req_ready` returns.
- **Reset mid-access:** assert `reset` during BEAT0 with `dready` low. Required: `dvalid` = 0 and state IDLE at the next edge, with no `rsp_valid`.

Source files
------------

// File: rtl/fwrisc_lsu.sv
// fwrisc_lsu: load/store unit between the fwrisc execute stage and the data bus.
// Places store data and strobes on the right byte lanes, extracts and extends load
// data, and bounds every bus beat with an optional timeout (TIMEOUT = 0 disables it).
// Build option FWRISC_LSU_MISALIGN_EN: when defined, accesses that cross a word
// boundary are split into two aligned beats; when undefined they are rejected with
// a misaligned error and no bus activity.
module fwrisc_lsu #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [1:0]            rsp_err_code,
    output logic [ADDR_WIDTH-1:0] daddr,
    output logic [31:0]           dwdata,
    input  logic [31:0]           drdata,
    output logic [3:0]            dstrb,
    output logic                  dwrite,
    output logic                  dvalid,
    input  logic                  dready
);

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

    localparam logic [1:0] ErrNone     = 2'b00;
    localparam logic [1:0] ErrMisalign = 2'b01;
    localparam logic [1:0] ErrTimeout  = 2'b10;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [31:0]           dwdata_q, dwdata_d;
    logic [3:0]            dstrb_q, dstrb_d;
    logic                  dwrite_q, dwrite_d;
    logic                  dvalid_q, dvalid_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [31:0]           cnt_inc;
    logic                  timed_out;

`ifdef FWRISC_LSU_MISALIGN_EN
    // Second-beat lanes/strobes captured at accept, plus beat-0 read data.
    logic [31:0]           hi_wdata_q, hi_wdata_d;
    logic [3:0]            hi_strb_q, hi_strb_d;
    logic [31:0]           b0_q, b0_d;
    logic [31:0]           req_hi;
`endif

    logic [7:0]            req_mask;
    logic [4:0]            req_shift;
    logic [31:0]           req_lo;
    logic                  reject;
    logic                  split_pending;

    // Extract the addressed bytes from the assembled beats and extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [63:0] raw, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] v;
        v = raw[{off, 3'b000} +: 32];
        case (size)
            2'b00:   load_extend = {{24{~uns & v[7]}}, v[7:0]};
            2'b01:   load_extend = {{16{~uns & v[15]}}, v[15:0]};
            default: load_extend = v;
        endcase
    endfunction

    // Byte-lane mask and shifted store data for the incoming request.
    always_comb begin
        case (req_size)
            2'b00:   req_mask = 8'b0000_0001;
            2'b01:   req_mask = 8'b0000_0011;
            default: req_mask = 8'b0000_1111;
        endcase
        req_mask  = req_mask << req_addr[1:0];
        req_shift = {req_addr[1:0], 3'b000};
        req_lo    = req_wdata << req_shift;
`ifdef FWRISC_LSU_MISALIGN_EN
        // A shift by 32 (offset 0) yields zero, which is never used anyway.
        req_hi    = req_wdata >> (6'd32 - {1'b0, req_shift});
`endif
    end

`ifdef FWRISC_LSU_MISALIGN_EN
    assign reject        = 1'b0;
    assign split_pending = |hi_strb_q;
`else
    assign reject        = |req_mask[7:4];
    assign split_pending = 1'b0;
`endif

    assign cnt_inc   = cnt_q + 32'd1;
    assign timed_out = (TIMEOUT > 0) && dvalid_q && !dready && (cnt_inc == TIMEOUT);

    // Next-state logic: request capture, beat sequencing, timeout and response.
    always_comb begin
        state_d  = state_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        dstrb_d  = dstrb_q;
        dwrite_d = dwrite_q;
        dvalid_d = dvalid_q;
        off_d    = off_q;
        size_d   = size_q;
        uns_d    = uns_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
`ifdef FWRISC_LSU_MISALIGN_EN
        hi_wdata_d = hi_wdata_q;
        hi_strb_d  = hi_strb_q;
        b0_d       = b0_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    off_d   = req_addr[1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    code_d  = ErrNone;
`ifdef FWRISC_LSU_MISALIGN_EN
                    hi_wdata_d = req_hi;
                    hi_strb_d  = req_mask[7:4];
                    b0_d       = '0;
`endif
                    if (reject) begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        code_d  = ErrMisalign;
                    end else begin
                        state_d  = StBeat0;
                        dvalid_d = 1'b1;
                        dwrite_d = req_write;
                        daddr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        dwdata_d = req_lo;
                        dstrb_d  = req_mask[3:0];
                        cnt_d    = '0;
                    end
                end
            end

            StBeat0: begin
                if (dready) begin
                    if (split_pending) begin
`ifdef FWRISC_LSU_MISALIGN_EN
                        state_d  = StBeat1;
                        b0_d     = drdata;
                        daddr_d  = daddr_q + ADDR_WIDTH'(4);
                        dwdata_d = hi_wdata_q;
                        dstrb_d  = hi_strb_q;
                        cnt_d    = '0;
`endif
                    end else begin
                        state_d  = StResp;
                        rdata_d  = dwrite_q ? '0
                                            : load_extend({32'b0, drdata}, off_q, size_q, uns_q);
                        dvalid_d = 1'b0;
                        dwrite_d = 1'b0;
                        daddr_d  = '0;
                        dwdata_d = '0;
                        dstrb_d  = '0;
                    end
                end else if (timed_out) begin
                    state_d  = StResp;
                    err_d    = 1'b1;
                    code_d   = ErrTimeout;
                    dvalid_d = 1'b0;
                    dwrite_d = 1'b0;
                    daddr_d  = '0;
                    dwdata_d = '0;
                    dstrb_d  = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            StBeat1: begin
`ifdef FWRISC_LSU_MISALIGN_EN
                if (dready) begin
                    state_d = StResp;
                    rdata_d = dwrite_q ? '0 : load_extend({drdata, b0_q}, off_q, size_q, uns_q);
                end else if (timed_out) begin
                    // Beat 0 writes already landed; only the second half is dropped.
                    state_d = StResp;
                    err_d   = 1'b1;
                    code_d  = ErrTimeout;
                end else begin
                    cnt_d = cnt_inc;
                end
                if (dready || timed_out) begin
                    dvalid_d = 1'b0;
                    dwrite_d = 1'b0;
                    daddr_d  = '0;
                    dwdata_d = '0;
                    dstrb_d  = '0;
                end
`else
                state_d = StIdle;
`endif
            end

            StResp: begin
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    // State and registered bus/response fields; reset abandons any beat silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            daddr_q  <= '0;
            dwdata_q <= '0;
            dstrb_q  <= '0;
            dwrite_q <= 1'b0;
            dvalid_q <= 1'b0;
            off_q    <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            code_q   <= ErrNone;
            cnt_q    <= '0;
`ifdef FWRISC_LSU_MISALIGN_EN
            hi_wdata_q <= '0;
            hi_strb_q  <= '0;
            b0_q       <= '0;
`endif
        end else begin
            state_q  <= state_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            dstrb_q  <= dstrb_d;
            dwrite_q <= dwrite_d;
            dvalid_q <= dvalid_d;
            off_q    <= off_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
`ifdef FWRISC_LSU_MISALIGN_EN
            hi_wdata_q <= hi_wdata_d;
            hi_strb_q  <= hi_strb_d;
            b0_q       <= b0_d;
`endif
        end
    end

    assign req_ready    = (state_q == StIdle) && !reset;
    assign rsp_valid    = (state_q == StResp);
    assign rsp_rdata    = rsp_valid ? rdata_q : '0;
    assign rsp_err      = rsp_valid & err_q;
    assign rsp_err_code = rsp_valid ? code_q : ErrNone;

    assign daddr  = daddr_q;
    assign dwdata = dwdata_q;
    assign dstrb  = dstrb_q;
    assign dwrite = dwrite_q;
    assign dvalid = dvalid_q;

endmodule

// File: tb/tb_fwrisc_lsu.sv
// tb_fwrisc_lsu: directed steps against fwrisc_lsu (TIMEOUT = 4), with expected
// responses and bus beats queued as each request is issued and compared on completion.
// Expectations follow FWRISC_LSU_MISALIGN_EN in the same way as the design.
module tb_fwrisc_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  rsp_err_code;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] drdata;
    logic [3:0]  dstrb;
    logic        dwrite;
    logic        dvalid;
    logic        dready;

    // Read data: rd1 is returned at rd1_addr, rd0 everywhere else.
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] rd1_addr;
    assign drdata = (daddr == rd1_addr) ? rd1 : rd0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
    } rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        write;
    } beat_t;

    rsp_t  exp_rsp[$];
    beat_t exp_beat[$];
    beat_t got_beat[$];

    int n_cmp   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    int dv_cnt  = 0;

    fwrisc_lsu #(
        .ADDR_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .rsp_err_code (rsp_err_code),
        .daddr        (daddr),
        .dwdata       (dwdata),
        .drdata       (drdata),
        .dstrb        (dstrb),
        .dwrite       (dwrite),
        .dvalid       (dvalid),
        .dready       (dready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Bus monitor: inputs change on the falling edge, so just after it they show what
    // the next rising edge will see.
    always @(negedge clock) begin
        #1;
        if (dvalid) dv_cnt <= dv_cnt + 1;
        if (dvalid && dready) got_beat.push_back('{daddr, dstrb, dwdata, dwrite});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rsp(input logic [31:0] rdata, input logic err, input logic [1:0] code);
        exp_rsp.push_back('{rdata, err, code});
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                             input logic wr);
        exp_beat.push_back('{a, s, wd, wr});
    endtask

    // Present one request for a single cycle, starting on a falling edge.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        check("req_ready before issue", 64'(req_ready), 64'h1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        acc_cyc      = cyc;
        @(negedge clock);
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        rsp_t e;
        bit   seen;
        seen = 1'b0;
        e    = exp_rsp.pop_front();
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check({tag, " rsp_valid seen"}, 64'(seen), 64'h1);
        if (seen) begin
            check({tag, " latency"}, 64'(cyc - acc_cyc), 64'(exp_lat));
            check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
            check({tag, " rsp_err"}, 64'(rsp_err), 64'(e.err));
            check({tag, " rsp_err_code"}, 64'(rsp_err_code), 64'(e.code));
            @(negedge clock);
            check({tag, " rsp_valid one cycle"}, 64'(rsp_valid), 64'h0);
            check({tag, " req_ready after rsp"}, 64'(req_ready), 64'h1);
        end
    endtask

    task automatic check_beats(input string tag);
        beat_t e;
        beat_t g;
        check({tag, " beat count"}, 64'(got_beat.size()), 64'(exp_beat.size()));
        while (exp_beat.size() > 0 && got_beat.size() > 0) begin
            e = exp_beat.pop_front();
            g = got_beat.pop_front();
            check({tag, " daddr"}, 64'(g.addr), 64'(e.addr));
            check({tag, " dstrb"}, 64'(g.strb), 64'(e.strb));
            check({tag, " dwdata"}, 64'(g.wdata), 64'(e.wdata));
            check({tag, " dwrite"}, 64'(g.write), 64'(e.write));
        end
        exp_beat.delete();
        got_beat.delete();
    endtask

    initial begin
        bit stray;
        int dv0;

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        dready       = 1'b1;
        rd0          = '0;
        rd1          = '0;
        rd1_addr     = 32'hFFFF_0000;

        // Reset state.
        repeat (2) @(negedge clock);
        check("reset req_ready low", 64'(req_ready), 64'h0);
        check("reset dvalid", 64'(dvalid), 64'h0);
        check("reset rsp_valid", 64'(rsp_valid), 64'h0);
        reset = 1'b0;
        @(negedge clock);
        check("post-reset req_ready", 64'(req_ready), 64'h1);
        check("post-reset daddr", 64'(daddr), 64'h0);
        check("post-reset dstrb", 64'(dstrb), 64'h0);
        check("post-reset dwdata", 64'(dwdata), 64'h0);

        // Aligned word load.
        rd0 = 32'hDEAD_BEEF;
        push_beat(32'h100, 4'hF, 32'h0, 1'b0);
        push_rsp(32'hDEAD_BEEF, 1'b0, 2'b00);
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        wait_rsp("lw 0x100", 2);
        check_beats("lw 0x100");

        // Byte loads at offset 2, signed then unsigned.
        rd0 = 32'h0080_0000;
        push_beat(32'h100, 4'b0100, 32'h0, 1'b0);
        push_rsp(32'hFFFF_FF80, 1'b0, 2'b00);
        issue(1'b0, 2'b00, 1'b0, 32'h102, 32'h0);
        wait_rsp("lb 0x102", 2);
        check_beats("lb 0x102");
        push_beat(32'h100, 4'b0100, 32'h0, 1'b0);
        push_rsp(32'h0000_0080, 1'b0, 2'b00);
        issue(1'b0, 2'b00, 1'b1, 32'h102, 32'h0);
        wait_rsp("lbu 0x102", 2);
        check_beats("lbu 0x102");

        // Halfword loads at offset 2.
        rd0 = 32'h8001_0000;
        push_beat(32'h100, 4'b1100, 32'h0, 1'b0);
        push_rsp(32'hFFFF_8001, 1'b0, 2'b00);
        issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        wait_rsp("lh 0x102", 2);
        check_beats("lh 0x102");
        push_beat(32'h100, 4'b1100, 32'h0, 1'b0);
        push_rsp(32'h0000_8001, 1'b0, 2'b00);
        issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
        wait_rsp("lhu 0x102", 2);
        check_beats("lhu 0x102");

        // Stores: half at offset 2, byte at offset 3 (upper wdata bits must not leak).
        push_beat(32'h200, 4'b1100, 32'h1234_0000, 1'b1);
        push_rsp(32'h0, 1'b0, 2'b00);
        issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_1234);
        wait_rsp("sh 0x202", 2);
        check_beats("sh 0x202");
        push_beat(32'h300, 4'b1000, 32'hAB00_0000, 1'b1);
        push_rsp(32'h0, 1'b0, 2'b00);
        issue(1'b1, 2'b00, 1'b0, 32'h303, 32'h1234_56AB);
        wait_rsp("sb 0x303", 2);
        check_beats("sb 0x303");

        // Misaligned accesses.
`ifdef FWRISC_LSU_MISALIGN_EN
        push_beat(32'h300, 4'b1110, 32'hB2C3_D400, 1'b1);
        push_beat(32'h304, 4'b0001, 32'h0000_00A1, 1'b1);
        push_rsp(32'h0, 1'b0, 2'b00);
        issue(1'b1, 2'b10, 1'b0, 32'h301, 32'hA1B2_C3D4);
        wait_rsp("sw 0x301", 3);
        check_beats("sw 0x301");

        rd0 = 32'h5566_7788;
        rd1 = 32'h1122_3344;
        rd1_addr = 32'h0;
        push_beat(32'hFFFF_FFFC, 4'b1100, 32'h0, 1'b0);
        push_beat(32'h0, 4'b0011, 32'h0, 1'b0);
        push_rsp(32'h3344_5566, 1'b0, 2'b00);
        issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0);
        wait_rsp("lw wrap", 3);
        check_beats("lw wrap");

        rd0 = 32'h8000_0000;
        rd1 = 32'h0000_00FF;
        rd1_addr = 32'h104;
        push_beat(32'h100, 4'b1000, 32'h0, 1'b0);
        push_beat(32'h104, 4'b0001, 32'h0, 1'b0);
        push_rsp(32'hFFFF_FF80, 1'b0, 2'b00);
        issue(1'b0, 2'b01, 1'b0, 32'h103, 32'h0);
        wait_rsp("lh 0x103", 3);
        check_beats("lh 0x103");
        rd1_addr = 32'hFFFF_0000;
`else
        dv0 = dv_cnt;
        push_rsp(32'h0, 1'b1, 2'b01);
        issue(1'b1, 2'b10, 1'b0, 32'h301, 32'hA1B2_C3D4);
        wait_rsp("sw 0x301", 1);
        check_beats("sw 0x301");
        check("sw 0x301 no dvalid", 64'(dv_cnt - dv0), 64'h0);

        push_rsp(32'h0, 1'b1, 2'b01);
        issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0);
        wait_rsp("lw 0xfffffffe", 1);
        check_beats("lw 0xfffffffe");

        push_rsp(32'h0, 1'b1, 2'b01);
        issue(1'b0, 2'b01, 1'b0, 32'h103, 32'h0);
        wait_rsp("lh 0x103", 1);
        check_beats("lh 0x103");
`endif

        // Timeout: dready held low for the whole beat.
        dready = 1'b0;
        dv0 = dv_cnt;
        push_rsp(32'h0, 1'b1, 2'b10);
        issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        wait_rsp("timeout", 5);
        check("timeout dvalid cycles", 64'(dv_cnt - dv0), 64'h4);
        check_beats("timeout");
        dready = 1'b1;

        // Reset in the middle of a stalled beat.
        dready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
        check("mid-access dvalid", 64'(dvalid), 64'h1);
        reset = 1'b1;
        @(negedge clock);
        check("reset abort dvalid", 64'(dvalid), 64'h0);
        check("reset abort daddr", 64'(daddr), 64'h0);
        check("reset abort rsp_valid", 64'(rsp_valid), 64'h0);
        reset  = 1'b0;
        dready = 1'b1;
        stray  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (rsp_valid || dvalid) stray = 1'b1;
        end
        check("reset abort no activity", 64'(stray), 64'h0);
        check_beats("reset abort");

        // A request while busy is ignored.
        dready = 1'b0;
        rd0 = 32'h0BAD_F00D;
        push_beat(32'h600, 4'hF, 32'h0, 1'b0);
        push_rsp(32'h0BAD_F00D, 1'b0, 2'b00);
        issue(1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
        check("busy req_ready low", 64'(req_ready), 64'h0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h700;
        req_wdata = 32'hFFFF_FFFF;
        @(negedge clock);
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        dready    = 1'b1;
        wait_rsp("busy ignore", 3);
        repeat (2) @(negedge clock);
        check_beats("busy ignore");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
